alu_pattern_runner: RTL and testbench

On-chip pattern applier and response checker for the 2-bit alu (ain, bin, sel -> zout). It sits directly upstream of the alu, driving its inputs, and consumes zout. It holds a small writable pattern store of {PI, expected PO, mask} entries, applies each entry, waits a settle window, and then strobes and compares the masked response. It reports pass/fail, the fail count and the index of the first failing pattern, replacing the simulation-only testbench flow with synthesizable hardware.

---
 rtl/alu_test_pkg.sv | 28 ++
 rtl/alu_run_fail_fifo.sv | 52 +++++
 rtl/alu_pattern_runner.sv | 127 ++++++++++++
 tb/tb_alu_pattern_runner.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_test_pkg.sv
// Shared constants, state encoding and pattern entry layout for the 2-bit alu pattern runner.
package alu_test_pkg;

   localparam int unsigned NINPUTS  = 5;
   localparam int unsigned NOUTPUTS = 2;

   // PI = {ain[1:0], bin[1:0], sel}; PO = {zout[1], zout[0]}
   localparam int unsigned AIN_LSB  = 3;
   localparam int unsigned BIN_LSB  = 1;
   localparam int unsigned SEL_BIT  = 0;
   localparam int unsigned ZOUT_MSB = 1;
   localparam int unsigned ZOUT_LSB = 0;

   typedef enum logic [2:0] {
      IDLE,
      APPLY,
      SETTLE,
      MEASURE,
      FINISH
   } run_state_t;

   typedef struct packed {
      logic [NINPUTS-1:0]  pi;
      logic [NOUTPUTS-1:0] xpct;
      logic [NOUTPUTS-1:0] mask;
   } pat_entry_t;

endpackage

// File: rtl/alu_run_fail_fifo.sv
// Small synchronous FIFO holding {idx, dut_po} of failing patterns; drops writes when full.
// Only present when ALU_RUN_FAIL_LOG_EN is defined.
`ifdef ALU_RUN_FAIL_LOG_EN
module alu_run_fail_fifo #(
   parameter int unsigned WIDTH = 6,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             full;
   logic             do_wr;
   logic             do_rd;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr && rst_n && !clr) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_wr && !do_rd)      count <= count + (PTR_W+1)'(1);
         else if (do_rd && !do_wr) count <= count - (PTR_W+1)'(1);
      end
   end

endmodule
`endif

// File: rtl/alu_pattern_runner.sv
// Applies stored {pi, xpct, mask} patterns to the 2-bit alu and checks masked responses.
// Optional fail log FIFO and its ports are enabled by defining ALU_RUN_FAIL_LOG_EN.
module alu_pattern_runner
   import alu_test_pkg::*;
#(
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned ADDR_W     = 4,
   parameter int unsigned SETTLE_CYC = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                pat_wr_en,
   input  logic [ADDR_W-1:0]   pat_wr_addr,
   input  logic [NINPUTS-1:0]  pat_wr_pi,
   input  logic [NOUTPUTS-1:0] pat_wr_xpct,
   input  logic [NOUTPUTS-1:0] pat_wr_mask,
   input  logic [ADDR_W:0]     num_pats,
   input  logic                start,
   output logic [NINPUTS-1:0]  dut_pi,
   input  logic [NOUTPUTS-1:0] dut_po,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [ADDR_W:0]     fail_count,
   output logic [ADDR_W-1:0]   first_fail_idx
`ifdef ALU_RUN_FAIL_LOG_EN
   ,
   input  logic                         log_rd_en,
   output logic [ADDR_W+NOUTPUTS-1:0]   log_rd_data,
   output logic                         log_empty
`endif
);

   localparam int unsigned SCNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   run_state_t        state;
   pat_entry_t        store [DEPTH];
   pat_entry_t        cur;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W:0]   idx_nxt;
   logic [ADDR_W:0]   num_run;
   logic [ADDR_W:0]   num_clamped;
   logic [SCNT_W-1:0] settle_cnt;
   logic              miss;

   assign cur         = store[idx];
   assign miss        = |((dut_po ^ cur.xpct) & cur.mask);
   assign idx_nxt     = {1'b0, idx} + (ADDR_W+1)'(1);
   assign num_clamped = (num_pats > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : num_pats;

   // Writes are gated by busy only, so a write in the start cycle lands before APPLY reads it.
   always_ff @(posedge clk) begin
      if (pat_wr_en && !busy)
         store[pat_wr_addr] <= '{pi: pat_wr_pi, xpct: pat_wr_xpct, mask: pat_wr_mask};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         dut_pi         <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         fail_count     <= '0;
         first_fail_idx <= '0;
         idx            <= '0;
         num_run        <= '0;
         settle_cnt     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  num_run        <= num_clamped;
                  idx            <= '0;
                  fail_count     <= '0;
                  first_fail_idx <= '0;
                  pass           <= 1'b0;
                  busy           <= 1'b1;
                  state          <= (num_pats == '0) ? FINISH : APPLY;
               end
            end
            APPLY: begin
               dut_pi     <= cur.pi;
               settle_cnt <= SCNT_W'(SETTLE_CYC - 1);
               state      <= SETTLE;
            end
            SETTLE: begin
               if (settle_cnt == '0) state <= MEASURE;
               else                  settle_cnt <= settle_cnt - SCNT_W'(1);
            end
            MEASURE: begin
               if (miss) begin
                  if (fail_count == '0) first_fail_idx <= idx;
                  if (fail_count != (ADDR_W+1)'(DEPTH)) fail_count <= fail_count + (ADDR_W+1)'(1);
               end
               idx   <= idx + ADDR_W'(1);
               state <= (idx_nxt == num_run) ? FINISH : APPLY;
            end
            FINISH: begin
               done  <= 1'b1;
               pass  <= (fail_count == '0);
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ALU_RUN_FAIL_LOG_EN
   alu_run_fail_fifo #(
      .WIDTH (ADDR_W + NOUTPUTS),
      .DEPTH (4)
   ) u_fail_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     ((state == IDLE) && start),
      .wr_en   ((state == MEASURE) && miss),
      .wr_data ({idx, dut_po}),
      .rd_en   (log_rd_en),
      .rd_data (log_rd_data),
      .empty   (log_empty)
   );
`endif

endmodule

// File: tb/tb_alu_pattern_runner.sv
// Directed bench for alu_pattern_runner driving a behavioural 2-bit alu with optional zout[1] stuck-at-0.
module tb_alu_pattern_runner;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pat_wr_en;
   logic [3:0] pat_wr_addr;
   logic [4:0] pat_wr_pi;
   logic [1:0] pat_wr_xpct;
   logic [1:0] pat_wr_mask;
   logic [4:0] num_pats;
   logic       start;
   logic [4:0] dut_pi;
   logic [1:0] dut_po;
   logic       busy;
   logic       done;
   logic       pass;
   logic [4:0] fail_count;
   logic [3:0] first_fail_idx;

   logic       stuck;
   logic [1:0] a, b, z;
   logic       s;

   int errors = 0;
   int checks = 0;

   logic [4:0] vpi [11] = '{5'b11101, 5'b00111, 5'b11111, 5'b11011, 5'b11010, 5'b00000,
                            5'b01110, 5'b11100, 5'b00100, 5'b01010, 5'b11110};
   logic [1:0] vx  [11] = '{2'b10, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00,
                            2'b00, 2'b01, 2'b10, 2'b10, 2'b10};

   always #5 clk = ~clk;

   assign a = dut_pi[alu_test_pkg::AIN_LSB +: 2];
   assign b = dut_pi[alu_test_pkg::BIN_LSB +: 2];
   assign s = dut_pi[alu_test_pkg::SEL_BIT];
   assign z = s ? (a & b) : (a + b);
   assign dut_po = stuck ? {1'b0, z[alu_test_pkg::ZOUT_LSB]} : z;

   alu_pattern_runner #(
      .DEPTH      (16),
      .ADDR_W     (4),
      .SETTLE_CYC (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pat_wr_en      (pat_wr_en),
      .pat_wr_addr    (pat_wr_addr),
      .pat_wr_pi      (pat_wr_pi),
      .pat_wr_xpct    (pat_wr_xpct),
      .pat_wr_mask    (pat_wr_mask),
      .num_pats       (num_pats),
      .start          (start),
      .dut_pi         (dut_pi),
      .dut_po         (dut_po),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .fail_count     (fail_count),
      .first_fail_idx (first_fail_idx)
   );

   task automatic write_pat(input logic [3:0] ad, input logic [4:0] pi,
                            input logic [1:0] x, input logic [1:0] m);
      pat_wr_en   = 1'b1;
      pat_wr_addr = ad;
      pat_wr_pi   = pi;
      pat_wr_xpct = x;
      pat_wr_mask = m;
      @(posedge clk); #1;
      pat_wr_en = 1'b0;
   endtask

   task automatic load_all;
      for (int i = 0; i < 11; i++) write_pat(4'(i), vpi[i], vx[i], 2'b11);
   endtask

   // Pulses start now; counts posedges until done is seen. extra_at / wr_at inject an
   // ignored start pulse or store write at the given cycle number (-1 = none).
   task automatic run(input logic [4:0] n, input int extra_at, input int wr_at, output int cycles);
      cycles   = 0;
      num_pats = n;
      start    = 1'b1;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk); #1;
         cycles    = k;
         start     = 1'b0;
         pat_wr_en = 1'b0;
         if (k == extra_at) start = 1'b1;
         if (k == wr_at) begin
            pat_wr_en   = 1'b1;
            pat_wr_addr = 4'd0;
            pat_wr_pi   = 5'b00000;
            pat_wr_xpct = 2'b11;
            pat_wr_mask = 2'b11;
         end
         if (done) break;
      end
      start     = 1'b0;
      pat_wr_en = 1'b0;
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL run_timeout: done=%b after %0d cycles, required 1", done, cycles);
      end
   endtask

   task automatic test_reset;
      checks++; if (dut_pi !== 5'd0)         begin errors++; $display("FAIL rst_dut_pi: got %b want 0", dut_pi); end
      checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0)           begin errors++; $display("FAIL rst_done: got %b want 0", done); end
      checks++; if (pass !== 1'b0)           begin errors++; $display("FAIL rst_pass: got %b want 0", pass); end
      checks++; if (fail_count !== 5'd0)     begin errors++; $display("FAIL rst_fail_count: got %0d want 0", fail_count); end
      checks++; if (first_fail_idx !== 4'd0) begin errors++; $display("FAIL rst_first_fail_idx: got %0d want 0", first_fail_idx); end
   endtask

   task automatic test_pass_run;
      int c;
      load_all();
      num_pats = 5'd11;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b want 1", busy); end
      for (int k = 2; k <= 200; k++) begin
         @(posedge clk); #1;
         c = k;
         if (k == 3) begin
            checks++;
            if (dut_pi !== vpi[0]) begin errors++; $display("FAIL first_pi: got %b want %b", dut_pi, vpi[0]); end
         end
         if (done) break;
      end
      checks++; if (c !== 46)            begin errors++; $display("FAIL pass_latency: got %0d want 46", c); end
      checks++; if (pass !== 1'b1)       begin errors++; $display("FAIL pass_pass: got %b want 1", pass); end
      checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL pass_busy_done: got %b want 0", busy); end
      checks++; if (fail_count !== 5'd0) begin errors++; $display("FAIL pass_fail_count: got %0d want 0", fail_count); end
      checks++; if (dut_pi !== vpi[10])  begin errors++; $display("FAIL last_pi_held: got %b want %b", dut_pi, vpi[10]); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0)       begin errors++; $display("FAIL done_one_cycle: got %b want 0", done); end
   endtask

   task automatic test_corrupt;
      int c;
      write_pat(4'd3, vpi[3], 2'b10, 2'b11);
      run(5'd11, -1, -1, c);
      checks++; if (pass !== 1'b0)           begin errors++; $display("FAIL corrupt_pass: got %b want 0", pass); end
      checks++; if (fail_count !== 5'd1)     begin errors++; $display("FAIL corrupt_fail_count: got %0d want 1", fail_count); end
      checks++; if (first_fail_idx !== 4'd3) begin errors++; $display("FAIL corrupt_first_idx: got %0d want 3", first_fail_idx); end
   endtask

   task automatic test_mask;
      int c;
      write_pat(4'd3, vpi[3], 2'b10, 2'b00);
      run(5'd11, -1, -1, c);
      checks++; if (pass !== 1'b1)       begin errors++; $display("FAIL mask_pass: got %b want 1", pass); end
      checks++; if (fail_count !== 5'd0) begin errors++; $display("FAIL mask_fail_count: got %0d want 0", fail_count); end
      write_pat(4'd3, vpi[3], vx[3], 2'b11);
   endtask

   task automatic test_stuck;
      int c;
      stuck = 1'b1;
      run(5'd11, -1, -1, c);
      stuck = 1'b0;
      checks++; if (pass !== 1'b0)           begin errors++; $display("FAIL stuck_pass: got %b want 0", pass); end
      checks++; if (fail_count !== 5'd5)     begin errors++; $display("FAIL stuck_fail_count: got %0d want 5", fail_count); end
      checks++; if (first_fail_idx !== 4'd0) begin errors++; $display("FAIL stuck_first_idx: got %0d want 0", first_fail_idx); end
   endtask

   task automatic test_zero;
      int c;
      run(5'd0, -1, -1, c);
      checks++; if (c !== 2)       begin errors++; $display("FAIL zero_latency: got %0d want 2", c); end
      checks++; if (pass !== 1'b1) begin errors++; $display("FAIL zero_pass: got %b want 1", pass); end
   endtask

   task automatic test_busy_ignores;
      int c;
      run(5'd11, 5, 9, c);
      checks++; if (c !== 46)            begin errors++; $display("FAIL busy_start_latency: got %0d want 46", c); end
      checks++; if (pass !== 1'b1)       begin errors++; $display("FAIL busy_write_pass: got %b want 1", pass); end
      checks++; if (fail_count !== 5'd0) begin errors++; $display("FAIL busy_write_fail_count: got %0d want 0", fail_count); end
   endtask

   task automatic test_clamp;
      int c;
      for (int i = 11; i < 16; i++) write_pat(4'(i), 5'b00000, 2'b00, 2'b11);
      run(5'd20, -1, -1, c);
      checks++; if (c !== 66)      begin errors++; $display("FAIL clamp_latency: got %0d want 66", c); end
      checks++; if (pass !== 1'b1) begin errors++; $display("FAIL clamp_pass: got %b want 1", pass); end
   endtask

   task automatic test_same_cycle;
      int c;
      pat_wr_en   = 1'b1;
      pat_wr_addr = 4'd0;
      pat_wr_pi   = vpi[0];
      pat_wr_xpct = 2'b01;
      pat_wr_mask = 2'b11;
      run(5'd1, -1, -1, c);
      checks++; if (c !== 6)             begin errors++; $display("FAIL same_latency: got %0d want 6", c); end
      checks++; if (fail_count !== 5'd1) begin errors++; $display("FAIL same_fail_count: got %0d want 1", fail_count); end
      write_pat(4'd0, vpi[0], vx[0], 2'b11);
   endtask

   task automatic test_reset_midrun;
      int c;
      logic saw_done;
      num_pats = 5'd11;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      @(posedge clk); #1;
      test_reset();
      rst_n    = 1'b1;
      saw_done = 1'b0;
      repeat (50) begin
         @(posedge clk); #1;
         if (done) saw_done = 1'b1;
      end
      checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b want 0", saw_done); end
      run(5'd11, -1, -1, c);
      checks++; if (c !== 46)            begin errors++; $display("FAIL rerun_latency: got %0d want 46", c); end
      checks++; if (pass !== 1'b1)       begin errors++; $display("FAIL rerun_pass: got %b want 1", pass); end
      checks++; if (fail_count !== 5'd0) begin errors++; $display("FAIL rerun_fail_count: got %0d want 0", fail_count); end
   endtask

   initial begin
      rst_n       = 1'b0;
      stuck       = 1'b0;
      pat_wr_en   = 1'b0;
      pat_wr_addr = '0;
      pat_wr_pi   = '0;
      pat_wr_xpct = '0;
      pat_wr_mask = '0;
      num_pats    = '0;
      start       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_pass_run();
      test_corrupt();
      test_mask();
      test_stuck();
      test_zero();
      test_busy_ignores();
      test_clamp();
      test_same_cycle();
      test_reset_midrun();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
